// File: rtl/mips_pkg.sv
// Shared pipeline constants and load-mode encodings for the MEM/WB datapath.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        LM_WORD   = 2'b00,
        LM_HALF_S = 2'b01,
        LM_BYTE_S = 2'b10,
        LM_BYTE_U = 2'b11
    } load_mode_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bundle: MEM entry and forwarding queries in, register-file write port,
// forwarding results and retired-write count out.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] mem_address;
    logic              mem_to_reg;
    logic              mem_reg_write;
    logic [1:0]        mem_load_mode;
    logic [REG_AW-1:0] mem_dest;
    logic              flush;
    logic [REG_AW-1:0] fwd_rs;
    logic [REG_AW-1:0] fwd_rt;
    logic              fwd_rs_hit;
    logic              fwd_rt_hit;
    logic [DATA_W-1:0] fwd_rs_data;
    logic [DATA_W-1:0] fwd_rt_data;
    logic [REG_AW-1:0] delay_write_register;
    logic [DATA_W-1:0] delay_write_data;
    logic              delay_in_RegWrite;
    logic [CNT_W-1:0]  wb_write_count;

    modport master (
        output mem_read_data, mem_address, mem_to_reg, mem_reg_write,
               mem_load_mode, mem_dest, flush, fwd_rs, fwd_rt,
        input  fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data,
               delay_write_register, delay_write_data, delay_in_RegWrite,
               wb_write_count
    );

    modport slave (
        input  mem_read_data, mem_address, mem_to_reg, mem_reg_write,
               mem_load_mode, mem_dest, flush, fwd_rs, fwd_rt,
        output fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data,
               delay_write_register, delay_write_data, delay_in_RegWrite,
               wb_write_count
    );

endinterface

// File: rtl/wb_stage_load_extract.sv
// Little-endian load lane extraction with sign/zero extension.
// Halfword selection uses offset bit 1 only; misaligned halfwords are not trapped.
module load_extract
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        offset_i,
    input  load_mode_e        mode_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = word_i;
        case (mode_i)
            LM_WORD:   data_o = word_i;
            LM_HALF_S: data_o = {{16{half_sel[15]}}, half_sel};
            LM_BYTE_S: data_o = {{24{byte_sel[7]}}, byte_sel};
            LM_BYTE_U: data_o = {24'd0, byte_sel};
            default:   data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB latch (S1), delayed register-file write latch (S2),
// two-level forwarding lookup and a retired-write counter.
module wb_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic       CLK,
    input  logic       RST,
    wb_stage_if.slave  wb
);

    logic                 s1_valid_q;
    logic [DATA_W-1:0]    s1_word_q;
    logic [DATA_W-1:0]    s1_addr_q;
    logic                 s1_to_reg_q;
    mips_pkg::load_mode_e s1_mode_q;
    logic [REG_AW-1:0]    s1_dest_q;

    logic                 s2_valid_q;
    logic [REG_AW-1:0]    s2_dest_q;
    logic [DATA_W-1:0]    s2_data_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 s1_valid_d;
    logic [DATA_W-1:0]    s1_load;
    logic [DATA_W-1:0]    s1_result_d;
    logic [CNT_W-1:0]     cnt_d;

    load_extract u_extract (
        .word_i   (s1_word_q),
        .offset_i (s1_addr_q[1:0]),
        .mode_i   (s1_mode_q),
        .data_o   (s1_load)
    );

    // A write to $0 is architecturally a no-op, so it never becomes valid.
    always_comb begin
        s1_valid_d  = wb.mem_reg_write & ~wb.flush & (wb.mem_dest != '0);
        s1_result_d = s1_to_reg_q ? s1_load : s1_addr_q;
        cnt_d       = cnt_q + CNT_W'(s1_valid_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s1_addr_q   <= '0;
            s1_to_reg_q <= 1'b0;
            s1_mode_q   <= mips_pkg::LM_WORD;
            s1_dest_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_dest_q   <= '0;
            s2_data_q   <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_word_q   <= wb.mem_read_data;
            s1_addr_q   <= wb.mem_address;
            s1_to_reg_q <= wb.mem_to_reg;
            s1_mode_q   <= mips_pkg::load_mode_e'(wb.mem_load_mode);
            s1_dest_q   <= wb.mem_dest;
            s2_valid_q  <= s1_valid_q;
            s2_dest_q   <= s1_dest_q;
            s2_data_q   <= s1_result_d;
            cnt_q       <= cnt_d;
        end
    end

    // S1 holds the younger entry and therefore wins over S2.
    always_comb begin
        wb.fwd_rs_hit  = 1'b0;
        wb.fwd_rs_data = '0;
        if (wb.fwd_rs != '0) begin
            if (s1_valid_q && (s1_dest_q == wb.fwd_rs)) begin
                wb.fwd_rs_hit  = 1'b1;
                wb.fwd_rs_data = s1_result_d;
            end else if (s2_valid_q && (s2_dest_q == wb.fwd_rs)) begin
                wb.fwd_rs_hit  = 1'b1;
                wb.fwd_rs_data = s2_data_q;
            end
        end
    end

    always_comb begin
        wb.fwd_rt_hit  = 1'b0;
        wb.fwd_rt_data = '0;
        if (wb.fwd_rt != '0) begin
            if (s1_valid_q && (s1_dest_q == wb.fwd_rt)) begin
                wb.fwd_rt_hit  = 1'b1;
                wb.fwd_rt_data = s1_result_d;
            end else if (s2_valid_q && (s2_dest_q == wb.fwd_rt)) begin
                wb.fwd_rt_hit  = 1'b1;
                wb.fwd_rt_data = s2_data_q;
            end
        end
    end

    assign wb.delay_in_RegWrite    = s2_valid_q;
    assign wb.delay_write_register = s2_dest_q;
    assign wb.delay_write_data     = s2_data_q;
    assign wb.wb_write_count       = cnt_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the MEM→WB pipeline interface; consumes the MEM stage outputs.
- Registers the MEM/WB entry, extracts and extends load data, and selects the ALU or memory result.
- Drives the one-cycle-delayed register-file write port (delay_write_register / delay_write_data / delay_in_RegWrite) back into the ID stage.
- Provides two-level forwarding lookups to EX and counts retired register writes.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register index width.
- CNT_W, 32, retired-write counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- mem_read_data  in  32  raw word read from data memory.
- mem_address  in  32  ALU result / memory address from MEM.
- mem_to_reg  in  1  1 = select load data, 0 = select ALU result.
- mem_reg_write  in  1  entry writes a register.
- mem_load_mode  in  2  00 word, 01 halfword signed, 10 byte signed, 11 byte unsigned.
- mem_dest  in  5  destination register index.
- flush  in  1  kill the entry being captured this cycle.
- fwd_rs, fwd_rt  in  5 each  EX source registers to look up.
- fwd_rs_hit, fwd_rt_hit  out  1 each  forwarding match.
- fwd_rs_data, fwd_rt_data  out  32 each  forwarded values.
- delay_write_register  out  5  register file write index.
- delay_write_data  out  32  register file write data.
- delay_in_RegWrite  out  1  register file write enable.
- wb_write_count  out  32  retired register writes.

Behaviour:
- Two register stages: S1 (MEM/WB latch) and S2 (delay latch). Every rising edge with RST=0, S2 takes S1's computed result and S1 takes the inputs.
- S1 valid = mem_reg_write & ~flush & (mem_dest != 0). A write to $0 is never valid.
- Load extraction is combinational from S1, little-endian:
  - Byte offset = addr[1:0].
  - Halfword uses addr[1] and ignores addr[0]; no misalignment trap.
  - Byte-signed and halfword-signed sign-extend; byte-unsigned zero-extends; word passes through.
- S1 result = mem_to_reg ? extracted load : address.
- delay_* outputs come directly from S2 registers. Latency: MEM inputs → delay_in_RegWrite high = 2 rising edges.
- wb_write_count increments by 1 on each edge where S1 valid enters S2. Wraps from 0xFFFFFFFF to 0; no saturation.
- Forwarding, combinational per port:
  - Hit if S1 valid and dest == query, else if S2 valid and dest == query.
  - S1 has priority over S2.
  - Query 0 never hits. On no hit, data = 0.
- Reset: all valid bits 0, all data/index registers 0, wb_write_count 0. Hence delay_in_RegWrite = 0, delay_write_register = 0, delay_write_data = 0, all fwd hits 0.
- Reset asserted mid-stream discards both in-flight entries; no write is emitted on the cycle after reset.
- flush kills only the entry being captured. An entry already in S1 still advances to S2 and writes.
- Back-to-back writes to the same register: both are emitted in order; forwarding returns the younger (S1) value.
- No stall input; the stage advances every cycle.

Decomposition:
- Shared package (mips_pkg): load-mode encodings LM_WORD=2'b00, LM_HALF_S=2'b01, LM_BYTE_S=2'b10, LM_BYTE_U=2'b11; constants DATA_W and REG_AW.
- One sub-module, load_extract: combinational word/offset/mode → 32-bit extended data. Reusable by MEM for store-side alignment checks.

Test Plan:
- Reset: hold RST 2 cycles with mem_reg_write=1 → delay_in_RegWrite=0, wb_write_count=0 throughout, and for one cycle after release.
- ALU write: mem_address=0x0000_1234, mem_to_reg=0, dest=8 → two edges later delay_write_register=8, delay_write_data=0x0000_1234, RegWrite=1; count=1.
- Loads on mem_read_data=0x80FF_7F01:
  - LM_BYTE_S, addr=...3 → 0xFFFF_FF80.
  - LM_BYTE_U, addr=...2 → 0x0000_00FF.
  - LM_HALF_S, addr=...0 → 0x0000_7F01.
  - LM_HALF_S, addr=...2 → 0xFFFF_80FF.
  - LM_WORD → 0x80FF_7F01.
- Forward priority: consecutive writes r5=0x11 then r5=0x22 → with query rs=5, fwd_rs_data=0x22 while both are in flight, then 0x22 from S2 only; query 0 never hits.
- Flush and $0: flush=1 on a dest=9 write, then a dest=0 write → no delay_in_RegWrite pulse for either, count unchanged.
- Counter wrap: preload count to 0xFFFF_FFFF via 2^32-1 writes (or force) then one write → 0x0000_0000.
